// File: rtl/sd_wr_sec_feeder_if.sv
// Bus between the sector feeder, the 16-bit read side of the frame FIFO and the SD write controller.
// Handshake: sd_wr_start_en opens a sector; every sd_wr_req cycle in transfer reads one FIFO word
// (r_fifo_rd_en), which appears on r_fifo_data/sd_wr_data after the next edge; sd_wr_busy frames the sector.
interface sd_wr_sec_feeder_if;
    logic        r_fifo_rd_en;
    logic [15:0] r_fifo_data;
    logic [9:0]  r_fifo_rd_cnt;
    logic        r_fifo_empty;
    logic        sd_wr_start_en;
    logic [31:0] sd_wr_sec_addr;
    logic        sd_wr_req;
    logic [15:0] sd_wr_data;
    logic        sd_wr_busy;

    modport master (
        output r_fifo_rd_en, sd_wr_start_en, sd_wr_sec_addr, sd_wr_data,
        input  r_fifo_data, r_fifo_rd_cnt, r_fifo_empty, sd_wr_req, sd_wr_busy
    );

    modport slave (
        input  r_fifo_rd_en, sd_wr_start_en, sd_wr_sec_addr, sd_wr_data,
        output r_fifo_data, r_fifo_rd_cnt, r_fifo_empty, sd_wr_req, sd_wr_busy
    );
endinterface

// File: rtl/sd_wr_sec_feeder.sv
// Frame-to-SD sector sequencer: requests a frame, then writes it to SD in 256-word sectors.
// Define SD_WR_FRAME_LOOP_EN to chain frames automatically up to MAX_FRAMES.
module sd_wr_sec_feeder #(
    parameter logic [15:0] FRAME_SECS = 16'd1920,
    parameter logic [31:0] START_SEC  = 32'd16384,
    parameter logic [8:0]  SEC_WORDS  = 9'd256,
    parameter logic [2:0]  DONE_PULSE = 3'd4,
    parameter logic [7:0]  MAX_FRAMES = 8'd16
) (
    input  logic                      i_sd_clk,
    input  logic                      i_sd_rst,
    input  logic                      i_frame_start,
    sd_wr_sec_feeder_if.master        bus,
    output logic                      o_wr_sd_sec_done,
    output logic [15:0]               o_sec_cnt,
    output logic [7:0]                o_frame_cnt,
    output logic                      o_busy,
    output logic                      o_underflow_err,
    output logic [3:0]                o_state
);

`ifdef SD_WR_FRAME_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_WAIT_DATA, S_START, S_ARM, S_XFER, S_WAIT_BUSY, S_NEXT, S_DONE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_pulse_cnt;
    logic [8:0]  r_word_cnt;
    logic [31:0] r_sec_addr;
    logic        r_start_en;
    logic        r_done;
    logic [15:0] r_sec_cnt;
    logic [7:0]  r_frame_cnt;
    logic        r_uflow;

    logic        w_rd_en;
    logic        w_data_ready;
    logic [15:0] w_sec_next;
    logic [7:0]  w_frame_next;

    // Reads only happen while a sector is open, so stray requests never drain the FIFO.
    assign w_rd_en      = (r_state == S_XFER) & bus.sd_wr_req;
    assign w_data_ready = (bus.r_fifo_rd_cnt >= {1'b0, SEC_WORDS});
    assign w_sec_next   = r_sec_cnt + 16'd1;
    assign w_frame_next = (r_frame_cnt == 8'hFF) ? r_frame_cnt : r_frame_cnt + 8'd1;

    always_ff @(posedge i_sd_clk) begin
        if (i_sd_rst) begin
            r_state     <= S_IDLE;
            r_pulse_cnt <= '0;
            r_word_cnt  <= '0;
            r_sec_addr  <= START_SEC;
            r_start_en  <= 1'b0;
            r_done      <= 1'b0;
            r_sec_cnt   <= '0;
            r_frame_cnt <= '0;
            r_uflow     <= 1'b0;
        end else begin
            if (w_rd_en && bus.r_fifo_empty) r_uflow <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_state     <= S_REQ;
                        r_done      <= 1'b1;
                        r_pulse_cnt <= '0;
                    end
                end
                S_REQ: begin
                    r_sec_cnt <= '0;
                    if (r_pulse_cnt == DONE_PULSE - 3'd1) begin
                        r_done  <= 1'b0;
                        r_state <= S_WAIT_DATA;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 3'd1;
                    end
                end
                S_WAIT_DATA: begin
                    if (w_data_ready && !bus.sd_wr_busy) begin
                        r_start_en <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_start_en <= 1'b0;
                    r_state    <= S_ARM;
                end
                S_ARM: begin
                    if (bus.sd_wr_busy) begin
                        r_word_cnt <= '0;
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_rd_en) begin
                        if (r_word_cnt == SEC_WORDS - 9'd1) begin
                            r_word_cnt <= '0;
                            r_state    <= S_WAIT_BUSY;
                        end else begin
                            r_word_cnt <= r_word_cnt + 9'd1;
                        end
                    end
                end
                S_WAIT_BUSY: begin
                    if (!bus.sd_wr_busy) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    // Address is never rewound between frames, so frames land back-to-back on the card.
                    r_sec_addr <= r_sec_addr + 32'd1;
                    r_sec_cnt  <= w_sec_next;
                    r_state    <= (w_sec_next == FRAME_SECS) ? S_DONE : S_WAIT_DATA;
                end
                S_DONE: begin
                    r_frame_cnt <= w_frame_next;
                    if (LOOP_EN && (w_frame_next < MAX_FRAMES)) begin
                        r_state     <= S_REQ;
                        r_done      <= 1'b1;
                        r_pulse_cnt <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.r_fifo_rd_en   = w_rd_en;
    assign bus.sd_wr_data     = bus.r_fifo_data;
    assign bus.sd_wr_start_en = r_start_en;
    assign bus.sd_wr_sec_addr = r_sec_addr;
    assign o_wr_sd_sec_done   = r_done;
    assign o_sec_cnt          = r_sec_cnt;
    assign o_frame_cnt        = r_frame_cnt;
    assign o_busy             = (r_state != S_IDLE);
    assign o_underflow_err    = r_uflow;
    assign o_state            = r_state;

endmodule

// File: tb/tb_sd_wr_sec_feeder.sv
// Bench for sd_wr_sec_feeder: FIFO and SD controller models, data scoreboard, sector/frame bookkeeping.
module tb_sd_wr_sec_feeder;
    localparam int FRAME_SECS = 4;
    localparam int MAX_FRAMES = 2;
    localparam int SEC_WORDS  = 256;
    localparam int DONE_PULSE = 4;
    localparam int START_SEC  = 16384;
`ifdef SD_WR_FRAME_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        done;
    logic [15:0] sec_cnt;
    logic [7:0]  frame_cnt;
    logic        busy;
    logic        uflow;
    logic [3:0]  state;

    sd_wr_sec_feeder_if bus();

    sd_wr_sec_feeder #(
        .FRAME_SECS(16'(FRAME_SECS)),
        .START_SEC (32'(START_SEC)),
        .SEC_WORDS (9'(SEC_WORDS)),
        .DONE_PULSE(3'(DONE_PULSE)),
        .MAX_FRAMES(8'(MAX_FRAMES))
    ) dut (
        .i_sd_clk        (clk),
        .i_sd_rst        (rst),
        .i_frame_start   (frame_start),
        .bus             (bus.master),
        .o_wr_sd_sec_done(done),
        .o_sec_cnt       (sec_cnt),
        .o_frame_cnt     (frame_cnt),
        .o_busy          (busy),
        .o_underflow_err (uflow),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          ovr_cnt = -1;
    bit          gate = 1'b0;
    int          tests = 0;
    int          fails = 0;
    bit          last_start, last_done;
    logic [31:0] start_addr;
    int          starts_total = 0, done_cycles = 0;
    int          sectors_done = 0, sec_in_frame = 0, frames_done = 0;
    bit          uflow_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic upd_fifo();
        int n;
        n = (ovr_cnt >= 0) ? ovr_cnt : fifo_q.size();
        bus.r_fifo_rd_cnt = (n > 1023) ? 10'd1023 : 10'(n);
        bus.r_fifo_empty  = (fifo_q.size() == 0);
    endtask

    task automatic push_word();
        logic [15:0] w;
        w = 16'($urandom);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        upd_fifo();
    endtask

    // One clock: sample pre-edge outputs, then serve the FIFO read the DUT made at that edge.
    task automatic tick();
        bit rd;
        #1;
        rd = bus.r_fifo_rd_en;
        chk("rd_en", 32'(rd), 32'(bus.sd_wr_req & gate));
        last_start = bus.sd_wr_start_en;
        last_done  = done;
        if (last_start) begin
            starts_total++;
            start_addr = bus.sd_wr_sec_addr;
        end
        if (last_done) done_cycles++;
        @(negedge clk);
        if (rd) begin
            if (fifo_q.size() > 0) bus.r_fifo_data = fifo_q.pop_front();
            else bus.r_fifo_data = 16'($urandom);
            upd_fifo();
            #1;
            if (exp_q.size() > 0) chk("data", 32'(bus.sd_wr_data), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run_sector(input bit lvl, input bit uf, input int abort_at);
        int starts0, n, reqs;
        starts0 = starts_total;
        if (uf) begin
            fifo_q.delete();
            exp_q.delete();
            ovr_cnt = SEC_WORDS;
            upd_fifo();
        end else if (lvl) begin
            while (fifo_q.size() < SEC_WORDS - 1) push_word();
            repeat (20) tick();
            chk("lvl255_nostart", starts_total - starts0, 0);
            push_word();
            tick();
            tick();
            chk("lvl256_start", 32'(last_start), 1);
        end else begin
            while (fifo_q.size() < SEC_WORDS) push_word();
        end
        n = 0;
        while (starts_total == starts0 && n < 300) begin
            tick();
            n++;
        end
        chk("start_seen", starts_total - starts0, 1);
        chk("start_addr", start_addr, START_SEC + sectors_done);
        chk("sec_cnt_at_start", 32'(sec_cnt), sec_in_frame);
        repeat ($urandom_range(1, 3)) tick();
        bus.sd_wr_busy = 1'b1;
        tick();
        gate = 1'b1;
        reqs = 0;
        while (reqs < SEC_WORDS) begin
            if (abort_at > 0 && reqs == abort_at) begin
                rst = 1'b1;
                bus.sd_wr_req = 1'b1;
                tick();
                rst = 1'b0;
                gate = 1'b0;
                repeat (5) tick();
                chk("rst_busy", 32'(busy), 0);
                chk("rst_addr", bus.sd_wr_sec_addr, START_SEC);
                chk("rst_sec_cnt", 32'(sec_cnt), 0);
                chk("rst_frame_cnt", 32'(frame_cnt), 0);
                chk("rst_uflow", 32'(uflow), 0);
                chk("rst_done", 32'(done), 0);
                bus.sd_wr_req = 1'b0;
                bus.sd_wr_busy = 1'b0;
                fifo_q.delete();
                exp_q.delete();
                upd_fifo();
                sectors_done = 0;
                frames_done = 0;
                uflow_exp = 1'b0;
                return;
            end
            bus.sd_wr_req = ($urandom_range(0, 3) != 0);
            if (bus.sd_wr_req) reqs++;
            tick();
        end
        bus.sd_wr_req = 1'b0;
        gate = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        chk("start_width", starts_total - starts0, 1);
        bus.sd_wr_busy = 1'b0;
        tick();
        tick();
        sectors_done++;
        sec_in_frame++;
        if (uf) uflow_exp = 1'b1;
        chk("addr_next", bus.sd_wr_sec_addr, START_SEC + sectors_done);
        chk("sec_cnt", 32'(sec_cnt), sec_in_frame);
        chk("uflow", 32'(uflow), 32'(uflow_exp));
        ovr_cnt = -1;
        upd_fifo();
    endtask

    task automatic run_frame(input bit pulse, input bit lvl, input bit uf, input int abort_at);
        sec_in_frame = 0;
        done_cycles = 0;
        if (pulse) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
            chk("done_lat", 32'(last_done), 1);
        end
        for (int s = 0; s < FRAME_SECS; s++) begin
            run_sector(lvl && s == 0, uf && s == 0, (s == 0) ? abort_at : 0);
            if (abort_at > 0) return;
            if (s == 0) chk("done_len", done_cycles, DONE_PULSE);
        end
        if (frames_done < 255) frames_done++;
        tick();
        chk("frame_cnt", 32'(frame_cnt), frames_done);
        chk("busy_end", 32'(busy), 32'(LOOP && frames_done < MAX_FRAMES));
    endtask

    initial begin
        bus.sd_wr_req   = 1'b0;
        bus.sd_wr_busy  = 1'b0;
        bus.r_fifo_data = 16'h0;
        upd_fifo();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_done", 32'(done), 0);
        chk("reset_start", 32'(bus.sd_wr_start_en), 0);
        chk("reset_addr", bus.sd_wr_sec_addr, START_SEC);
        chk("reset_sec_cnt", 32'(sec_cnt), 0);
        chk("reset_frame_cnt", 32'(frame_cnt), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_uflow", 32'(uflow), 0);
        bus.sd_wr_req = 1'b1;
        repeat (3) tick();
        bus.sd_wr_req = 1'b0;
        run_frame(1'b1, 1'b1, 1'b0, 0);
`ifdef SD_WR_FRAME_LOOP_EN
        run_frame(1'b0, 1'b0, 1'b0, 0);
`endif
        chk("uflow_clear", 32'(uflow), 0);
        run_frame(1'b1, 1'b0, 1'b1, 0);
        run_frame(1'b1, 1'b0, 1'b0, 100);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
